// File: rtl/unidade_controle_varredura.sv
// Moore sweep controller for the contador_163 + comparador_85 datapath:
// clears the counter, then steps it until it matches chaves (acerto) or passes it (erro).
module unidade_controle_varredura #(
    parameter int unsigned PASSO_CICLOS = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       igual,
    input  logic       maior,
    input  logic       fim,
    output logic       zera,
    output logic       conta,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic [3:0] db_estado
);

    localparam int unsigned PW = $clog2(PASSO_CICLOS) + 1;
    localparam int unsigned ALVO_INT = (PASSO_CICLOS >= 2) ? (PASSO_CICLOS - 2) : 0;
    localparam logic [PW-1:0] ALVO = PW'(ALVO_INT);

    typedef enum logic [3:0] {
        INICIAL = 4'h0,
        PREPARA = 4'h1,
        COMPARA = 4'h2,
        ESPERA  = 4'h3,
        PROXIMO = 4'h4,
        ACERTO  = 4'hA,
        ERRO    = 4'hE
    } estado_t;

    estado_t       estado, estado_prox;
    logic [PW-1:0] presc, presc_prox;

    // State and prescaler registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
            presc  <= '0;
        end else begin
            estado <= estado_prox;
            presc  <= presc_prox;
        end
    end

    // Next-state logic and Moore output decode
    always_comb begin
        estado_prox = estado;
        presc_prox  = presc;
        zera        = 1'b0;
        conta       = 1'b0;
        pronto      = 1'b0;
        acertou     = 1'b0;
        errou       = 1'b0;
        unique case (estado)
            INICIAL: begin
                if (iniciar) estado_prox = PREPARA;
            end
            PREPARA: begin
                zera        = 1'b1;
                estado_prox = COMPARA;
            end
            COMPARA: begin
                // igual outranks fim so that chaves=15 still ends in ACERTO
                if (igual)                  estado_prox = ACERTO;
                else if (maior)             estado_prox = ERRO;
                else if (fim)               estado_prox = ERRO;
                else if (PASSO_CICLOS == 1) estado_prox = PROXIMO;
                else begin
                    estado_prox = ESPERA;
                    presc_prox  = '0;
                end
            end
            ESPERA: begin
                presc_prox = presc + PW'(1);
                if (presc == ALVO) estado_prox = PROXIMO;
            end
            PROXIMO: begin
                conta       = 1'b1;
                estado_prox = COMPARA;
            end
            ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
                if (iniciar) estado_prox = PREPARA;
            end
            ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
                if (iniciar) estado_prox = PREPARA;
            end
            default: estado_prox = INICIAL;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_varredura.sv
// Self-checking bench: two controllers (PASSO_CICLOS=1 and 3), each driving a small
// counter/comparator datapath, checked against a sweep-outcome reference model.
module tb_unidade_controle_varredura;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar   [2];
    logic [3:0] chaves    [2];
    logic [3:0] cnt       [2];
    logic       igual     [2];
    logic       maior     [2];
    logic       fim       [2];
    logic       zera      [2];
    logic       conta     [2];
    logic       pronto    [2];
    logic       acertou   [2];
    logic       errou     [2];
    logic [3:0] db_estado [2];

    int passo [2] = '{1, 3};
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    unidade_controle_varredura #(.PASSO_CICLOS(1)) u_dut1 (
        .clock(clock), .reset(reset), .iniciar(iniciar[0]),
        .igual(igual[0]), .maior(maior[0]), .fim(fim[0]),
        .zera(zera[0]), .conta(conta[0]), .pronto(pronto[0]),
        .acertou(acertou[0]), .errou(errou[0]), .db_estado(db_estado[0])
    );

    unidade_controle_varredura #(.PASSO_CICLOS(3)) u_dut3 (
        .clock(clock), .reset(reset), .iniciar(iniciar[1]),
        .igual(igual[1]), .maior(maior[1]), .fim(fim[1]),
        .zera(zera[1]), .conta(conta[1]), .pronto(pronto[1]),
        .acertou(acertou[1]), .errou(errou[1]), .db_estado(db_estado[1])
    );

    // Datapath stand-in: 4-bit counter (not touched by reset) plus comparator
    for (genvar g = 0; g < 2; g++) begin : g_dp
        assign igual[g] = (cnt[g] == chaves[g]);
        assign maior[g] = (cnt[g] > chaves[g]);
        assign fim[g]   = (cnt[g] == 4'd15);
        always @(posedge clock) begin
            if (zera[g])       cnt[g] <= 4'd0;
            else if (conta[g]) cnt[g] <= cnt[g] + 4'd1;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Outcome of a sweep: counter value j is compared at edge 1+j*(p+1) after PREPARA
    function automatic void modelo(input int p, input int k, input int ch_at, input int ch_val,
                                   output int est, output int lat, output int pul, output int fin);
        bit feito = 0;
        est = 0; lat = 0; pul = 0; fin = 0;
        for (int j = 0; j < 16; j++) begin
            int eff;
            if (!feito) begin
                eff = (ch_at >= 0 && j >= ch_at) ? ch_val : k;
                if (j == eff || j > eff || j == 15) begin
                    est   = (j == eff) ? 10 : 14;
                    lat   = 2 + j * (p + 1);
                    pul   = j;
                    fin   = j;
                    feito = 1;
                end
            end
        end
    endfunction

    task automatic run(input int i, input int k, input int ch_at, input int ch_val, input bit hold);
        int est, lat, pul, fin;
        int pulses = 0, last = -1, gap_bad = 0, wide_bad = 0, strobe_bad = 0;
        int obs_lat = -1;
        bit prev_conta = 0, done = 0;
        modelo(passo[i], k, ch_at, ch_val, est, lat, pul, fin);
        @(negedge clock);
        chaves[i]  = 4'(k);
        iniciar[i] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if (!hold) iniciar[i] = 1'b0;
        chk("prepara_estado", int'(db_estado[i]), 1);
        chk("prepara_zera", int'(zera[i]), 1);
        chk("prepara_conta", int'(conta[i]), 0);
        for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
            @(posedge clock);
            @(negedge clock);
            if (ch_at >= 0 && int'(cnt[i]) == ch_at) chaves[i] = 4'(ch_val);
            if (zera[i]) strobe_bad++;
            if (conta[i]) begin
                pulses++;
                if (prev_conta) wide_bad++;
                if (last >= 0 && cyc - last != passo[i] + 1) gap_bad++;
                last = cyc;
                if (db_estado[i] != 4'h4) strobe_bad++;
            end
            prev_conta = conta[i];
            if (pronto[i]) begin
                done    = 1;
                obs_lat = cyc;
            end
        end
        iniciar[i] = 1'b0;
        if (!done) chk("timeout", 0, 1);
        chk("latencia", obs_lat, lat);
        chk("estado_final", int'(db_estado[i]), est);
        chk("acertou", int'(acertou[i]), est == 10 ? 1 : 0);
        chk("errou", int'(errou[i]), est == 14 ? 1 : 0);
        chk("pulsos_conta", pulses, pul);
        chk("contagem", int'(cnt[i]), fin);
        chk("conta_largura", wide_bad, 0);
        chk("conta_intervalo", gap_bad, 0);
        chk("strobe_fora", strobe_bad, 0);
        chaves[i] = 4'($urandom_range(0, 15));
        @(posedge clock);
        @(negedge clock);
        chk("mantem_final", int'(db_estado[i]), est);
    endtask

    initial begin
        bit ok;
        iniciar[0] = 1'b0; iniciar[1] = 1'b0;
        chaves[0]  = 4'd0; chaves[1]  = 4'd0;
        reset = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            chk("rst_estado", int'(db_estado[i]), 0);
            chk("rst_saidas", int'({zera[i], conta[i], pronto[i], acertou[i], errou[i]}), 0);
        end
        reset = 1'b1;
        @(negedge clock);
        chk("inicial_parado", int'(db_estado[0]), 0);

        run(0, 5, -1, 0, 0);
        run(1, 5, -1, 0, 0);
        run(0, 0, -1, 0, 0);
        run(1, 0, -1, 0, 1);
        run(0, 15, -1, 0, 0);
        run(1, 15, -1, 0, 0);
        run(0, 9, 4, 2, 0);
        run(0, 9, -1, 0, 1);
        run(1, 3, 1, 12, 0);

        // Reset while in PROXIMO
        @(negedge clock);
        chaves[0]  = 4'd9;
        iniciar[0] = 1'b1;
        @(negedge clock);
        iniciar[0] = 1'b0;
        ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clock);
            if (db_estado[0] == 4'h4) ok = 1;
        end
        chk("achou_proximo", int'(ok), 1);
        chk("proximo_conta", int'(conta[0]), 1);
        reset = 1'b0;
        #1;
        chk("rst_async_estado", int'(db_estado[0]), 0);
        chk("rst_async_conta", int'(conta[0]), 0);
        chk("rst_async_zera", int'(zera[0]), 0);
        @(negedge clock);
        reset = 1'b1;
        run(0, 7, -1, 0, 0);

        for (int r = 0; r < 12; r++) begin
            int i  = int'($urandom_range(0, 1));
            int k  = int'($urandom_range(0, 15));
            int ca = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
            run(i, k, ca, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
